mont_param_gen: RTL

Parametrised generator of the Montgomery constants for the RSA datapath. Given a modulus `n`, it produces:
- `R = 2^WIDTH mod n` in mode R;
- `T = R^2 mod n = 2^(2·WIDTH) mod n` in mode T;
- optionally `n' = -n^-1 mod 2^WIDTH`.

It uses a bit-serial double-and-reduce datapath instead of a wide `%` operator. It sits ahead of the modular-exponentiation core and is started once per key load.

---
 rtl/mont_pkg.sv | 24 ++
 rtl/mod_dbl_step.sv | 34 +++
 rtl/mont_param_gen.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/mont_pkg.sv
// -----------------------------------------------------------------------------
// mont_pkg
// Shared definitions for the Montgomery constant generator:
//   OP_R / OP_T      - operation select values for the 'mode' input
//   mont_state_t     - controller state encoding {IDLE, RUN, DONE}
//   mont_iter_count  - number of double-and-reduce iterations for a mode
// -----------------------------------------------------------------------------
package mont_pkg;

    localparam logic OP_R = 1'b0;
    localparam logic OP_T = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mont_state_t;

    // R needs WIDTH doublings of 1, T = R^2 mod n needs 2*WIDTH doublings.
    function automatic int unsigned mont_iter_count(input logic mode, input int unsigned width);
        return (mode == OP_T) ? (2 * width) : width;
    endfunction

endpackage

// File: rtl/mod_dbl_step.sv
// -----------------------------------------------------------------------------
// mod_dbl_step
// Combinational modular doubling: res = (2*acc) mod n, assuming acc < n.
// Because acc < n, 2*acc < 2n, so a single conditional subtract is enough,
// even when the MSB of n is set (the doubled value is kept WIDTH+1 bits wide).
// Ports:
//   acc  in  WIDTH  current accumulator, must be < n
//   n    in  WIDTH  modulus
//   res  out WIDTH  reduced doubled value
// -----------------------------------------------------------------------------
module mod_dbl_step #(
    parameter int WIDTH = 4096
) (
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] n,
    output logic [WIDTH-1:0] res
);

    logic [WIDTH:0] dbl;
    logic [WIDTH:0] diff;

    // Double with one extra bit of headroom, then subtract n once if needed;
    // the difference is guaranteed to fit back into WIDTH bits.
    always_comb begin
        dbl  = {acc, 1'b0};
        diff = dbl - {1'b0, n};
        if (dbl >= {1'b0, n}) begin
            res = diff[WIDTH-1:0];
        end else begin
            res = dbl[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/mont_param_gen.sv
// -----------------------------------------------------------------------------
// mont_param_gen
// Generates Montgomery constants for modulus n with a bit-serial
// double-and-reduce loop: R = 2^WIDTH mod n (mode OP_R) or
// T = 2^(2*WIDTH) mod n (mode OP_T). Started once per key load.
// Optional feature macro: MONT_NPRIME_EN adds the nprime output
// (-n^-1 mod 2^WIDTH, computed by a Hensel lift in parallel) and rejects
// even moduli as invalid.
// Ports:
//   clk     in   1      clock, rising edge
//   rst     in   1      synchronous active-high reset, highest priority
//   go      in   1      start request, accepted in IDLE or DONE
//   mode    in   1      OP_R / OP_T, latched at start
//   n       in   WIDTH  modulus, latched at start
//   r       out  WIDTH  result, valid while done
//   nprime  out  WIDTH  -n^-1 mod 2^WIDTH (MONT_NPRIME_EN only)
//   busy    out  1      iterating
//   done    out  1      result ready (level)
//   err     out  1      invalid modulus, qualified by done
// -----------------------------------------------------------------------------
module mont_param_gen
    import mont_pkg::*;
#(
    parameter int WIDTH = 4096,
    parameter int CNT_W = $clog2(2 * WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             go,
    input  logic             mode,
    input  logic [WIDTH-1:0] n,
    output logic [WIDTH-1:0] r,
`ifdef MONT_NPRIME_EN
    output logic [WIDTH-1:0] nprime,
`endif
    output logic             busy,
    output logic             done,
    output logic             err
);

    mont_state_t      state, state_next;
    logic [WIDTH-1:0] acc, acc_next;
    logic [WIDTH-1:0] n_q, n_next;
    logic             mode_q, mode_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             err_q, err_next;
    logic [WIDTH-1:0] dbl_res;
    logic [CNT_W-1:0] cnt_last;
    logic             bad_mod;

`ifdef MONT_NPRIME_EN
    logic [WIDTH:0]   s, s_next;
    logic [WIDTH-1:0] x, x_next;
    logic [WIDTH+1:0] s_sum;
`endif

    mod_dbl_step #(.WIDTH(WIDTH)) u_dbl (
        .acc (acc),
        .n   (n_q),
        .res (dbl_res)
    );

    // Index of the final iteration, counted from zero.
    assign cnt_last = CNT_W'(mont_iter_count(mode_q, WIDTH) - 1);

    // A modulus below 2 has no meaningful residues; an even modulus has no
    // inverse mod 2^WIDTH, so it is rejected only when nprime is produced.
    always_comb begin
        bad_mod = (n < WIDTH'(2));
`ifdef MONT_NPRIME_EN
        if (!n[0]) begin
            bad_mod = 1'b1;
        end
`endif
    end

    // Controller state and datapath registers; reset clears everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            acc    <= '0;
            n_q    <= '0;
            mode_q <= OP_R;
            cnt    <= '0;
            err_q  <= 1'b0;
`ifdef MONT_NPRIME_EN
            s      <= '0;
            x      <= '0;
`endif
        end else begin
            state  <= state_next;
            acc    <= acc_next;
            n_q    <= n_next;
            mode_q <= mode_next;
            cnt    <= cnt_next;
            err_q  <= err_next;
`ifdef MONT_NPRIME_EN
            s      <= s_next;
            x      <= x_next;
`endif
        end
    end

`ifdef MONT_NPRIME_EN
    // Hensel step candidate: (s + n) fits in WIDTH+2 bits before the shift.
    assign s_sum = {1'b0, s} + {2'b00, n_q};
`endif

    // Next-state logic. A start latches the operands and either reports a
    // bad modulus straight away or enters RUN; RUN performs one reduce-double
    // per cycle and ignores go until the last iteration completes.
    always_comb begin
        state_next = state;
        acc_next   = acc;
        n_next     = n_q;
        mode_next  = mode_q;
        cnt_next   = cnt;
        err_next   = err_q;
`ifdef MONT_NPRIME_EN
        s_next     = s;
        x_next     = x;
`endif
        case (state)
            IDLE, DONE: begin
                if (go) begin
                    n_next    = n;
                    mode_next = mode;
                    cnt_next  = '0;
`ifdef MONT_NPRIME_EN
                    s_next    = {{WIDTH{1'b0}}, 1'b1};
                    x_next    = '0;
`endif
                    if (bad_mod) begin
                        acc_next   = '0;
                        err_next   = 1'b1;
                        state_next = DONE;
                    end else begin
                        acc_next   = {{(WIDTH-1){1'b0}}, 1'b1};
                        err_next   = 1'b0;
                        state_next = RUN;
                    end
                end
            end
            RUN: begin
                acc_next = dbl_res;
                cnt_next = cnt + CNT_W'(1);
`ifdef MONT_NPRIME_EN
                // Bits of x are shifted in from the top so that after WIDTH
                // steps the bit from the first iteration sits at bit 0.
                if (cnt < CNT_W'(WIDTH)) begin
                    x_next = {s[0], x[WIDTH-1:1]};
                    if (s[0]) begin
                        s_next = s_sum[WIDTH+1:1];
                    end else begin
                        s_next = s >> 1;
                    end
                end
`endif
                if (cnt == cnt_last) begin
                    state_next = DONE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign r    = acc;
    assign busy = (state == RUN);
    assign done = (state == DONE);
    assign err  = err_q;
`ifdef MONT_NPRIME_EN
    assign nprime = x;
`endif

endmodule
